// File: rtl/neopixel_frame_seq.sv
// Frame sequencer feeding a single-pixel serial writer from a local RGB store.
// Define NEOPIXEL_BRIGHTNESS_EN to add a global brightness scaler applied at pixel load.
module neopixel_frame_seq #(
    parameter int unsigned NUM_PIXELS   = 8,
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned BUSY_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_r,
    input  logic [7:0]        wr_g,
    input  logic [7:0]        wr_b,
    input  logic              start,
`ifdef NEOPIXEL_BRIGHTNESS_EN
    input  logic [7:0]        brightness,
`endif
    input  logic              ds_busy,
    output logic              ds_valid,
    output logic [7:0]        pixel_r,
    output logic [7:0]        pixel_g,
    output logic [7:0]        pixel_b,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int unsigned AW1    = ADDR_W + 1;
    localparam int unsigned BCNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int unsigned LCNT_W = $clog2(LATCH_CYCLES + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] WAIT_LO = 3'd4;
    localparam logic [2:0] NEXT    = 3'd5;
    localparam logic [2:0] LATCH   = 3'd6;

    logic [23:0]       store [NUM_PIXELS];

    logic [2:0]        state_q,     state_d;
    logic [ADDR_W-1:0] index_q,     index_d;
    logic [BCNT_W-1:0] busy_cnt_q,  busy_cnt_d;
    logic [LCNT_W-1:0] latch_cnt_q, latch_cnt_d;
    logic [23:0]       pix_q,       pix_d;
    logic              valid_q,     valid_d;
    logic              fbusy_q,     fbusy_d;
    logic              done_q,      done_d;
    logic              tmo_q,       tmo_d;
    logic [23:0]       load_px_c;

    // Frame store: no reset, writes allowed at any time, out-of-range addresses dropped
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < AW1'(NUM_PIXELS))) begin
            store[wr_addr] <= {wr_r, wr_g, wr_b};
        end
    end

`ifdef NEOPIXEL_BRIGHTNESS_EN
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    always_comb begin
        load_px_c = {scale_ch(store[index_q][23:16], brightness),
                     scale_ch(store[index_q][15:8],  brightness),
                     scale_ch(store[index_q][7:0],   brightness)};
    end
`else
    always_comb begin
        load_px_c = store[index_q];
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        busy_cnt_d  = busy_cnt_q;
        latch_cnt_d = latch_cnt_q;
        pix_d       = pix_q;
        tmo_d       = tmo_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pix_d   = load_px_c;
                state_d = STROBE;
            end
            STROBE: begin
                busy_cnt_d = '0;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                if (ds_busy) begin
                    state_d = WAIT_LO;
                end else if (busy_cnt_q == BCNT_W'(BUSY_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    busy_cnt_d = busy_cnt_q + BCNT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!ds_busy) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (index_q == ADDR_W'(NUM_PIXELS - 1)) begin
                    latch_cnt_d = '0;
                    state_d     = LATCH;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                    state_d = LOAD;
                end
            end
            LATCH: begin
                if (latch_cnt_q == LCNT_W'(LATCH_CYCLES - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + LCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == STROBE);
        fbusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            index_q     <= '0;
            busy_cnt_q  <= '0;
            latch_cnt_q <= '0;
            pix_q       <= '0;
            valid_q     <= 1'b0;
            fbusy_q     <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            busy_cnt_q  <= busy_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            pix_q       <= pix_d;
            valid_q     <= valid_d;
            fbusy_q     <= fbusy_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
        end
    end

    assign ds_valid    = valid_q;
    assign pixel_r     = pix_q[23:16];
    assign pixel_g     = pix_q[15:8];
    assign pixel_b     = pix_q[7:0];
    assign frame_busy  = fbusy_q;
    assign frame_done  = done_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_neopixel_frame_seq.sv
// Randomized bench for neopixel_frame_seq with a behavioural writer model and frame-level reference.
module tb_neopixel_frame_seq;

    localparam int unsigned NP = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned LC = 600;
    localparam int unsigned BT = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_r = '0, wr_g = '0, wr_b = '0;
    logic          start = 1'b0;
    logic          ds_busy = 1'b0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
    logic [7:0]    brightness = 8'd255;
`endif
    logic          ds_valid, frame_busy, frame_done, timeout_err;
    logic [7:0]    pixel_r, pixel_g, pixel_b;

    always #5 clk = ~clk;

    neopixel_frame_seq #(
        .NUM_PIXELS(NP), .ADDR_W(AW), .LATCH_CYCLES(LC), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .start(start),
`ifdef NEOPIXEL_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .ds_busy(ds_busy), .ds_valid(ds_valid),
        .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
        .frame_busy(frame_busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Writer model: busy high for wh cycles starting wd cycles after each valid
    int wd = 3, wh = 20;
    bit w_en = 1'b1;
    int last_v = -1000000;
    initial forever begin
        @(negedge clk);
        if (ds_valid) last_v = cyc;
        ds_busy = w_en && (cyc >= last_v + wd) && (cyc < last_v + wd + wh);
    end

    int          valid_t[$];
    logic [23:0] valid_px[$];
    int          done_t[$];
    initial forever begin
        @(negedge clk);
        if (ds_valid) begin
            valid_t.push_back(cyc);
            valid_px.push_back({pixel_r, pixel_g, pixel_b});
        end
        if (frame_done) done_t.push_back(cyc);
    end

    logic [23:0] shadow [NP];
    logic [23:0] exp_px [NP];

    function automatic logic [23:0] scl(input logic [23:0] c);
`ifdef NEOPIXEL_BRIGHTNESS_EN
        int b;
        b = int'(brightness) + 1;
        return {8'((int'(c[23:16]) * b) / 256), 8'((int'(c[15:8]) * b) / 256),
                8'((int'(c[7:0]) * b) / 256)};
`else
        return c;
`endif
    endfunction

    task automatic wr_px(input int idx, input logic [23:0] val);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(idx);
        {wr_r, wr_g, wr_b} = val;
        @(negedge clk);
        wr_en = 1'b0;
        shadow[idx] = val;
    endtask

    task automatic load_exp();
        for (int i = 0; i < NP; i++) exp_px[i] = scl(shadow[i]);
    endtask

    task automatic start_frame(output int t0);
        valid_t.delete(); valid_px.delete(); done_t.delete();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("frame_busy_on", 32'(frame_busy), 32'd1);
    endtask

    task automatic wait_valids(input int n);
        int b = 0;
        while (valid_t.size() < n && b < 5000) begin
            @(negedge clk);
            b++;
        end
        if (valid_t.size() < n) check("valid_wait_timeout", 32'(valid_t.size()), 32'(n));
    endtask

    task automatic wait_done();
        int b = 0;
        while (done_t.size() == 0 && b < 20000) begin
            @(negedge clk);
            b++;
        end
        if (done_t.size() == 0) check("frame_done_timeout", 32'd0, 32'd1);
        repeat (8) @(negedge clk);
    endtask

    // Frame-level expectations: w is the wait per pixel (busy delay+hold, or the timeout)
    task automatic check_frame(input string nm, input int t0, input int w);
        int n;
        n = (valid_t.size() < NP) ? valid_t.size() : NP;
        check({nm, "_n_valid"}, 32'(valid_t.size()), 32'(NP));
        if (n > 0) check({nm, "_latency"}, 32'(valid_t[0] - t0), 32'd2);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_px%0d", nm, i), 32'(valid_px[i]), 32'(exp_px[i]));
            if (i > 0)
                check($sformatf("%s_gap%0d", nm, i), 32'(valid_t[i] - valid_t[i-1]), 32'(w + 3));
        end
        check({nm, "_n_done"}, 32'(done_t.size()), 32'd1);
        if (done_t.size() > 0 && n > 0)
            check({nm, "_latch"}, 32'(done_t[0] - valid_t[n-1]), 32'(w + 2 + LC));
        check({nm, "_busy_off"}, 32'(frame_busy), 32'd0);
    endtask

    task automatic run_frame(input string nm);
        int t0;
        load_exp();
        start_frame(t0);
        wait_done();
        check_frame(nm, t0, w_en ? wd + wh : BT);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_valid"}, 32'(ds_valid), 32'd0);
        check({nm, "_pixel"}, 32'({pixel_r, pixel_g, pixel_b}), 32'd0);
        check({nm, "_fbusy"}, 32'(frame_busy), 32'd0);
        check({nm, "_fdone"}, 32'(frame_done), 32'd0);
        check({nm, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int t0;
`ifdef NEOPIXEL_BRIGHTNESS_EN
        logic [7:0] br_set [3];
        int         br_r   [3];
        br_set = '{8'd127, 8'd255, 8'd0};
        br_r   = '{100, 200, 0};
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");

        for (int i = 0; i < NP; i++) wr_px(i, {8'(i), 8'(8'h10 + i), 8'(8'h80 + i)});
        wd = 3; wh = 20;
        run_frame("basic");
        check("basic_tmo", 32'(timeout_err), 32'd0);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NP; i++) wr_px(i, 24'($urandom));
            wd = $urandom_range(1, 5);
            wh = $urandom_range(1, 12);
            run_frame($sformatf("rand%0d", k));
        end

        // Writes during pixel 2: later index appears this frame, earlier index next frame
        wd = 3; wh = 20;
        load_exp();
        start_frame(t0);
        wait_valids(3);
        wr_px(5, 24'hFFFFFF);
        wr_px(1, 24'h000000);
        exp_px[5] = scl(24'hFFFFFF);
        wait_done();
        check_frame("midwr", t0, wd + wh);
        run_frame("postwr");

        // Start during WAIT_LO of pixel 3 must be ignored
        load_exp();
        start_frame(t0);
        wait_valids(4);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check_frame("ignstart", t0, wd + wh);
        repeat (40) @(negedge clk);
        check("ignstart_no_restart", 32'(valid_t.size()), 32'(NP));

        // Reset during WAIT_LO of pixel 4
        load_exp();
        start_frame(t0);
        wait_valids(5);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("midrst");
        repeat (30) @(negedge clk);
        check("midrst_idle", 32'(valid_t.size()), 32'd5);
        run_frame("postrst");

`ifdef NEOPIXEL_BRIGHTNESS_EN
        wr_px(0, {8'd200, 8'($urandom), 8'($urandom)});
        for (int k = 0; k < 3; k++) begin
            brightness = br_set[k];
            run_frame($sformatf("br%0d", k));
            if (valid_px.size() > 0)
                check($sformatf("br%0d_r", k), 32'(valid_px[0][23:16]), 32'(br_r[k]));
        end
        brightness = 8'd255;
`endif

        // Writer never answers: every pixel times out, frame still completes
        w_en = 1'b0;
        run_frame("timeout");
        check("timeout_err_set", 32'(timeout_err), 32'd1);
        w_en = 1'b1;
        run_frame("sticky");
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/neopixel_frame_seq.md
Name: neopixel_frame_seq

Overview:
- Upstream feeder for the single-pixel serial writer.
- Holds a frame of NUM_PIXELS RGB values in a local register file, written by the host or control logic.
- On start, presents each pixel in turn on the writer's valid/pixel_r/g/b inputs and paces on its busy output.
- Ends each frame with a low-latch gap so the strip latches the data.

Parameters:
- NUM_PIXELS, 8, pixels per frame (1..256).
- ADDR_W, 3, pixel address width; must satisfy 2**ADDR_W >= NUM_PIXELS.
- LATCH_CYCLES, 600, clk cycles of idle after the last pixel (50 us at 12 MHz).
- BUSY_TIMEOUT, 1024, clk cycles to wait for downstream busy to rise before the pixel is abandoned.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write a pixel into the frame store
- wr_addr  in  ADDR_W  pixel index to write
- wr_r / wr_g / wr_b  in  8 each  colour to store
- start  in  1  begin sending the frame; sampled only in IDLE
- ds_busy  in  1  busy output from the downstream writer
- ds_valid  out  1  one-cycle load strobe to the writer
- pixel_r / pixel_g / pixel_b  out  8 each  colour presented to the writer
- frame_busy  out  1  high from start acceptance until LATCH completes
- frame_done  out  1  one-cycle pulse when LATCH completes
- timeout_err  out  1  sticky flag, set when any busy-rise timeout occurs

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: ds_valid=0, pixel_*=0, frame_busy=0, frame_done=0, timeout_err=0, state=IDLE, index=0, counters=0. Frame store is not cleared.
- Reset mid-frame: next cycle is IDLE with all outputs at reset values. The downstream writer may finish its current pixel on its own.
- Frame store writes:
  - Write occurs on the clk edge when wr_en=1 and wr_addr<NUM_PIXELS.
  - Writes with wr_addr>=NUM_PIXELS are ignored.
  - Writes are accepted in every state, including during a frame.
  - Each pixel is read from the store in the LOAD cycle. A write to a later index in the same frame is therefore sent; a write to an earlier index shows up in the next frame.
- States:
  - IDLE: frame_busy=0. If start=1: index<=0, go to LOAD. Otherwise stay.
  - LOAD: pixel_*<=store[index] (registered), go to STROBE.
  - STROBE: ds_valid=1 for exactly this cycle, busy_cnt<=0, go to WAIT_HI.
  - WAIT_HI:
    - If ds_busy=1, go to WAIT_LO.
    - Else if busy_cnt==BUSY_TIMEOUT-1: set timeout_err, go to NEXT.
    - Else busy_cnt++.
  - WAIT_LO: hold until ds_busy=0, then go to NEXT. pixel_* stay stable throughout.
  - NEXT: if index==NUM_PIXELS-1, latch_cnt<=0 and go to LATCH; else index++ and go to LOAD.
  - LATCH: ds_valid=0; latch_cnt++. When latch_cnt==LATCH_CYCLES-1, pulse frame_done and go to IDLE.
- frame_busy=1 in every state except IDLE.
- A start arriving outside IDLE is ignored. It is not queued.
- Latency: start at cycle T gives the first ds_valid at T+2.
- Minimum frame length: NUM_PIXELS*(4+busy-wait) + LATCH_CYCLES + 1 cycles.
- ds_busy already high in STROBE: WAIT_HI sees it and advances immediately. The writer's busy is registered, so it never reflects the new pixel that early; the spec accepts this.
- Index uses ADDR_W bits and never wraps, since NEXT terminates at NUM_PIXELS-1.
- timeout_err is cleared only by rst.

Optional Feature:
- Macro: NEOPIXEL_BRIGHTNESS_EN.
- With the macro defined:
  - Adds input port brightness [7:0].
  - In LOAD, each channel becomes (c*(brightness+1))>>8, with a 16-bit product truncated to 8 bits.
  - brightness=255 gives the identity; brightness=0 gives 0.
  - brightness is sampled in the LOAD cycle.
- Without the macro: no brightness port; channels pass through unscaled.

Test Plan:
- Reset, write store[0..7] = {r=i, g=0x10+i, b=0x80+i}, pulse start; a writer model raises busy 3 cycles after valid and holds it 20 cycles -> 8 ds_valid pulses in index order 0..7 with the matching pixel values, then LATCH_CYCLES quiet cycles, then one frame_done pulse, then frame_busy=0.
- Model never raises busy -> each pixel is abandoned after 1024 cycles and timeout_err=1; the frame still completes and frame_done is pulsed.
- start pulsed again in WAIT_LO of pixel 3 -> ignored; exactly 8 ds_valid pulses and one frame_done.
- During the wait on pixel 2, write store[5]=0xFFFFFF and store[1]=0x000000 -> pixel 5 is sent as FF/FF/FF; pixel 1 is sent with its old value this frame and 00 in the next frame.
- rst asserted in WAIT_LO of pixel 4 -> next cycle all outputs are 0 and state is IDLE; a following start sends from index 0.
- NEOPIXEL_BRIGHTNESS_EN, brightness=127, store r=200 -> pixel_r=100; brightness=255 -> 200; brightness=0 -> 0.
